pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Slew-limited, watchdog-protected motor-output controller that sits between the host Wishbone bus and the 4-channel PWM width registers. The host writes target widths and arm/failsafe control into this block's register file. On every update tick it walks the channels and issues Wishbone master writes of slew-limited widths to the PWM block at offsets 0x10/0x12/0x14/0x16. If the host stops refreshing targets, it forces a programmable failsafe width.

## Interface
Parameters:
- NCH, 4, number of channels (PWM offsets 0x10 + 2·ch)
- SLEW, 16, maximum width change per channel per tick
- TICK_DIV, 1000, tick period in wb_clk_i cycles (≥ 2·NCH+4)
- WDOG_TICKS, 100, ticks without a target write before failsafe

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  host slave strobes
- wb_adr_i  in  7  host address; [4:0] decoded
- wb_dat_i  in  16  host write data
- wb_dat_o  out  16  host read data
- wb_ack_o  out  1  host ack
- m_cyc_o, m_stb_o, m_we_o  out  1  master strobes to PWM block (m_we_o=1 whenever m_cyc_o)
- m_adr_o  out  7  PWM register offset
- m_dat_o  out  16  width to write
- m_ack_i  in  1  PWM block ack

## Operation
- Slave registers: 0x00 CTRL (bit0 arm R/W; bit1 write-1 clears failsafe and the watchdog counter, reads 0); 0x02 STATUS RO (bit0 armed, bit1 failsafe, bit2 busy, bit3 overrun, sticky, cleared by reading STATUS); 0x04 FS_WIDTH R/W; 0x10+2·ch TGT[ch] R/W. Other addresses: writes ignored, reads 0.
- Slave ack: registered one-cycle pulse, the cycle after cyc&stb is seen with ack low. The write commits on the same edge that raises ack.
- Per-channel effective target: if !armed, 0; else if failsafe, FS_WIDTH; else TGT[ch].
- Slew, normal armed mode only: cur' = tgt if |tgt−cur| ≤ SLEW, else cur ± SLEW. Unsigned 16-bit, no wrap or saturation past tgt.
- Disarm and failsafe bypass slew: cur jumps to the effective target at the next step.
- FSM: IDLE → STEP(ch) computes cur[ch] → WRITE drives cyc/stb/adr/dat, held until m_ack_i → ch+1 goes to STEP, last channel returns to IDLE. All channels are written every tick, even when unchanged.
- Tick while not IDLE: latch one pending tick and start it on return to IDLE. A second tick while one is pending sets overrun and is dropped.
- Watchdog: counts ticks while armed and not failsafe. Any TGT write resets it. Reaching WDOG_TICKS sets failsafe (sticky). Disarm resets the count but does not clear failsafe.
- Reset: all outputs 0, cur=0, TGT=0, FS_WIDTH=0, armed=0, failsafe=0, overrun=0, tick and watchdog counters 0. An in-flight master cycle drops immediately.

## Timing
- Tick asserted in cycle T → STEP at T+1 → m_cyc_o/m_stb_o high from T+2.
- With a zero-wait slave (ack in the same cycle as stb), each channel takes 2 cycles; NCH=4 completes by T+9.
- The STEP for a channel uses the TGT/CTRL values registered at that cycle. A host write landing on the same edge takes effect on the next tick.

## Structure
- Shared package: register offsets (CTRL, STATUS, FS_WIDTH, TGT base, PWM width base 0x10), STATUS bit indices, FSM state enum.
- One sub-module, pwm_tick_gen: TICK_DIV counter emitting a one-cycle tick pulse.

## Test plan
- Arm, write TGT0=100, SLEW=16 → PWM writes at 0x10 of 16, 32, … 96, 100, 100 on successive ticks; other channels receive 0.
- Armed with TGT1=1000 and cur=1000, write TGT1=990 → next tick writes exactly 990.
- Stop TGT writes for 100 ticks with FS_WIDTH=300 → failsafe bit set and all channels write 300 on the next tick. Clear via CTRL bit1 and write TGT → slew resumes from 300.
- Disarm mid-ramp → next tick writes 0 to all four channels.
- PWM slave stalls ack for 3·TICK_DIV cycles → overrun bit set, m_cyc_o held until ack, then the pending tick runs. Reading STATUS clears overrun.
- Assert wb_rst_i during WRITE → m_cyc_o low asynchronously, STATUS=0, first post-reset tick writes 0s.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for the slew-limited PWM ramp controller: register map,
// STATUS bit positions and the channel-walk FSM states.
package pwm_ramp_ctrl_pkg;

  localparam logic [4:0] ADR_CTRL     = 5'h00;
  localparam logic [4:0] ADR_STATUS   = 5'h02;
  localparam logic [4:0] ADR_FS_WIDTH = 5'h04;
  localparam logic [4:0] ADR_TGT_BASE = 5'h10;

  localparam logic [6:0] PWM_WIDTH_BASE = 7'h10;

  localparam int ST_ARMED    = 0;
  localparam int ST_FAILSAFE = 1;
  localparam int ST_BUSY     = 2;
  localparam int ST_OVERRUN  = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_WRITE
  } ramp_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module pwm_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)  cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Host-programmed, slew-limited, watchdog-protected width writer: each tick it
// walks all channels and writes the next width to the PWM block over Wishbone.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int SLEW       = 16,
  parameter int TICK_DIV   = 1000,
  parameter int WDOG_TICKS = 100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [6:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [6:0]  m_adr_o,
  output logic [15:0] m_dat_o,
  input  logic        m_ack_i
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW  = $clog2(WDOG_TICKS + 1);
  localparam logic [15:0] SLEW_W = 16'(SLEW);

  logic tick;

  pwm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .tick    (tick)
  );

  logic [4:0]     adr;
  logic           unused_adr;
  logic           host_req, host_wr, host_rd;
  logic           tgt_hit;
  logic [CHW-1:0] tgt_idx;
  logic           tgt_wr, ctrl_wr, fs_wr, fs_clr, status_rd;

  assign adr        = wb_adr_i[4:0];
  assign unused_adr = ^wb_adr_i[6:5];
  assign host_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign host_wr    = host_req & wb_we_i;
  assign host_rd    = host_req & ~wb_we_i;
  assign tgt_hit    = adr[4] && !adr[0] && (int'(adr[3:1]) < NCH);
  assign tgt_idx    = CHW'(adr[3:1]);
  assign tgt_wr     = host_wr && tgt_hit;
  assign ctrl_wr    = host_wr && (adr == ADR_CTRL);
  assign fs_wr      = host_wr && (adr == ADR_FS_WIDTH);
  assign fs_clr     = ctrl_wr && wb_dat_i[1];
  assign status_rd  = host_rd && (adr == ADR_STATUS);

  logic           armed_q, failsafe_q, overrun_q, tick_pend_q;
  logic [15:0]    fs_width_q;
  logic [15:0]    tgt_q [NCH];
  logic [15:0]    cur_q [NCH];
  logic [WW-1:0]  wd_q;
  ramp_state_e    state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           do_step;
  logic [15:0]    rd_data;

  always_comb begin
    rd_data = '0;
    if (adr == ADR_CTRL) begin
      rd_data[0] = armed_q;
    end else if (adr == ADR_STATUS) begin
      rd_data[ST_ARMED]    = armed_q;
      rd_data[ST_FAILSAFE] = failsafe_q;
      rd_data[ST_BUSY]     = (state_q != S_IDLE);
      rd_data[ST_OVERRUN]  = overrun_q;
    end else if (adr == ADR_FS_WIDTH) begin
      rd_data = fs_width_q;
    end else if (tgt_hit) begin
      rd_data = tgt_q[tgt_idx];
    end
  end

  // NOTE: the target array is small and must read back 0 after reset, so it is reset like any flop.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      armed_q    <= 1'b0;
      fs_width_q <= '0;
      for (int i = 0; i < NCH; i++) tgt_q[i] <= '0;
    end else begin
      wb_ack_o <= host_req;
      if (host_rd) wb_dat_o <= rd_data;
      if (ctrl_wr) armed_q <= wb_dat_i[0];
      if (fs_wr)   fs_width_q <= wb_dat_i;
      if (tgt_wr)  tgt_q[tgt_idx] <= wb_dat_i;
    end
  end

  // Watchdog only ages while armed and healthy; failsafe stays until the host clears it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_q       <= '0;
      failsafe_q <= 1'b0;
    end else if (fs_clr) begin
      wd_q       <= '0;
      failsafe_q <= 1'b0;
    end else if (!armed_q || tgt_wr) begin
      wd_q <= '0;
    end else if (tick && !failsafe_q) begin
      if (wd_q == WW'(WDOG_TICKS - 1)) begin
        failsafe_q <= 1'b1;
        wd_q       <= '0;
      end else begin
        wd_q <= wd_q + WW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tick_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE) tick_pend_q <= tick_pend_q && tick;
      else if (tick)         tick_pend_q <= 1'b1;
      if (tick && (state_q != S_IDLE) && tick_pend_q) overrun_q <= 1'b1;
      else if (status_rd)                             overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch can form.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    do_step = 1'b0;
    case (state_q)
      S_IDLE: if (tick || tick_pend_q) begin
        state_d = S_STEP;
        ch_d    = '0;
      end
      S_STEP: begin
        do_step = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: if (m_ack_i) begin
        if (ch_q == CHW'(NCH - 1)) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = S_STEP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [15:0] cur_sel, eff_tgt, next_cur;

  always_comb begin
    cur_sel  = cur_q[ch_q];
    eff_tgt  = !armed_q ? 16'h0 : (failsafe_q ? fs_width_q : tgt_q[ch_q]);
    next_cur = eff_tgt;
    if (armed_q && !failsafe_q) begin
      if (eff_tgt > cur_sel && (eff_tgt - cur_sel) > SLEW_W)
        next_cur = cur_sel + SLEW_W;
      else if (cur_sel > eff_tgt && (cur_sel - eff_tgt) > SLEW_W)
        next_cur = cur_sel - SLEW_W;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NCH; i++) cur_q[i] <= '0;
    end else if (do_step) begin
      cur_q[ch_q] <= next_cur;
    end
  end

  // Master strobes decode straight from the state flop so reset drops them at once.
  logic in_write;
  assign in_write = (state_q == S_WRITE);
  assign m_cyc_o  = in_write;
  assign m_stb_o  = in_write;
  assign m_we_o   = in_write;
  assign m_adr_o  = in_write ? (PWM_WIDTH_BASE + 7'({ch_q, 1'b0})) : '0;
  assign m_dat_o  = in_write ? cur_q[ch_q] : '0;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized self-checking bench for pwm_ramp_ctrl against a tick-level
// behavioural model of targets, slew, watchdog and failsafe.
module tb_pwm_ramp_ctrl;

  localparam int NCH        = 4;
  localparam int SLEW       = 16;
  localparam int TICK_DIV   = 40;
  localparam int WDOG_TICKS = 10;

  localparam logic [6:0] A_CTRL = 7'h00, A_STATUS = 7'h02, A_FS = 7'h04, A_TGT = 7'h10;

  logic        clk, rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [6:0]  wb_adr_i;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o;
  logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i;
  logic [6:0]  m_adr_o;
  logic [15:0] m_dat_o;
  logic        stall;

  pwm_ramp_ctrl #(.NCH(NCH), .SLEW(SLEW), .TICK_DIV(TICK_DIV), .WDOG_TICKS(WDOG_TICKS)) dut (
    .wb_clk_i(clk),     .wb_rst_i(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .m_cyc_o(m_cyc_o),   .m_stb_o(m_stb_o),   .m_we_o(m_we_o),
    .m_adr_o(m_adr_o),   .m_dat_o(m_dat_o),   .m_ack_i(m_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait PWM slave unless the bench holds it stalled.
  assign m_ack_i = m_cyc_o & m_stb_o & ~stall;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [6:0] adr; logic [15:0] dat; logic we; } mwr_t;
  mwr_t mq[$];

  always @(negedge clk)
    if (!rst && m_cyc_o && m_stb_o && m_ack_i) mq.push_back('{adr: m_adr_o, dat: m_dat_o, we: m_we_o});

  // Reference model, one update per tick.
  int cur_m[NCH], tgt_m[NCH], last_dat[NCH];
  int fs_w_m, wd_m;
  bit armed_m, fs_m;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin cur_m[i] = 0; tgt_m[i] = 0; end
    fs_w_m = 0; wd_m = 0; armed_m = 0; fs_m = 0;
  endtask

  task automatic model_tick();
    if (armed_m && !fs_m) begin
      wd_m++;
      if (wd_m == WDOG_TICKS) begin fs_m = 1; wd_m = 0; end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!armed_m)                cur_m[i] = 0;
      else if (fs_m)               cur_m[i] = fs_w_m;
      else if (tgt_m[i] > cur_m[i]) cur_m[i] = (cur_m[i] + SLEW < tgt_m[i]) ? cur_m[i] + SLEW : tgt_m[i];
      else                         cur_m[i] = (cur_m[i] - SLEW > tgt_m[i]) ? cur_m[i] - SLEW : tgt_m[i];
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [6:0] a);
    logic [4:0] a5;
    a5 = a[4:0];
    if (a5 == 5'h00) return {15'b0, armed_m};
    if (a5 == 5'h02) return {14'b0, fs_m, armed_m};
    if (a5 == 5'h04) return 16'(fs_w_m);
    if (a5[4] && !a5[0] && int'(a5[3:1]) < NCH) return 16'(tgt_m[a5[3:1]]);
    return 16'h0;
  endfunction

  task automatic host_write(input logic [6:0] a, input logic [15:0] d);
    int n;
    logic [4:0] a5;
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = a; wb_dat_i = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) check("wr_ack_timeout", 0, 1);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    a5 = a[4:0];
    if (a5 == 5'h00) begin
      armed_m = d[0];
      if (d[1]) begin fs_m = 0; wd_m = 0; end
      if (!armed_m) wd_m = 0;
    end else if (a5 == 5'h04) begin
      fs_w_m = d;
    end else if (a5[4] && !a5[0] && int'(a5[3:1]) < NCH) begin
      tgt_m[a5[3:1]] = d;
      wd_m = 0;
    end
  endtask

  task automatic host_read(input logic [6:0] a, output logic [15:0] d);
    int n;
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) check("rd_ack_timeout", 0, 1);
    d = wb_dat_o;
    wb_cyc_i = 0; wb_stb_i = 0;
  endtask

  // Waits for one tick's worth of PWM writes and checks them against the model.
  task automatic run_tick(input string tag);
    int waited;
    mwr_t e;
    waited = 0;
    while (mq.size() < NCH && waited < 2 * TICK_DIV + 20) begin @(negedge clk); waited++; end
    model_tick();
    if (mq.size() < NCH) begin
      check({tag, "_timeout"}, mq.size(), NCH);
      mq.delete();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      e = mq.pop_front();
      check($sformatf("%s_adr%0d", tag, i), e.adr, 7'h10 + 7'(2 * i));
      check($sformatf("%s_dat%0d", tag, i), e.dat, cur_m[i]);
      check($sformatf("%s_we%0d", tag, i), e.we, 1);
      last_dat[i] = e.dat;
    end
  endtask

  task automatic wait_mcyc(input string tag);
    int n;
    n = 0;
    while (!m_cyc_o && n < 2 * TICK_DIV + 20) begin @(negedge clk); n++; end
    check({tag, "_mcyc_wait"}, m_cyc_o, 1);
  endtask

  initial begin
    logic [15:0] rd;
    logic [6:0]  a;
    int          v, ch;

    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [15:0] rd;
    logic [6:0]  a;
    int          v, ch, guard;
    logic [6:0]  rd_set[10];

    rd_set = '{7'h00, 7'h02, 7'h04, 7'h10, 7'h12, 7'h14, 7'h16, 7'h06, 7'h18, 7'h13};
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0;
    stall = 0; rst = 1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;

    check("rst_m_cyc", m_cyc_o, 0);
    check("rst_m_dat", m_dat_o, 0);
    check("rst_ack", wb_ack_o, 0);
    host_read(A_STATUS, rd);
    check("rst_status", rd, 0);

    // Ramp channel 0 to 100 from zero.
    host_write(A_CTRL, 16'h1);
    host_write(A_TGT, 16'd100);
    for (int k = 0; k < 8; k++) begin
      run_tick("ramp");
      check($sformatf("ramp_ch0_%0d", k), last_dat[0], (16 * (k + 1) < 100) ? 16 * (k + 1) : 100);
      check($sformatf("ramp_ch3_%0d", k), last_dat[3], 0);
      host_write(A_TGT, 16'd100);
    end

    // Settle channel 1 at 1000, then a step of 10 lands exactly.
    host_write(A_TGT + 7'h2, 16'd1000);
    guard = 0;
    while (cur_m[1] != 1000 && guard < 80) begin
      run_tick("to1000");
      host_write(A_TGT + 7'h2, 16'd1000);
      guard++;
    end
    host_write(A_TGT + 7'h2, 16'd990);
    run_tick("step990");
    check("step990_ch1", last_dat[1], 990);

    // Randomized host traffic between ticks.
    for (int t = 0; t < 30; t++) begin
      run_tick("rand");
      for (int op = 0; op < int'($urandom_range(0, 4)); op++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: begin
            ch = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 1) == 1) v = cur_m[ch] + int'($urandom_range(0, 2 * SLEW + 2)) - (SLEW + 1);
            else                           v = $urandom_range(0, 65535);
            if (v < 0) v = 0;
            if (v > 65535) v = 65535;
            host_write(A_TGT + 7'(2 * ch), 16'(v));
          end
          5: host_write({2'($urandom_range(0, 3)), 5'h00},
                        {14'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
          6: host_write(A_FS, 16'($urandom_range(0, 65535)));
          7: host_write(rd_set[$urandom_range(7, 9)], 16'($urandom_range(0, 65535)));
          default: begin
            a = {2'($urandom_range(0, 3)), rd_set[$urandom_range(0, 9)][4:0]};
            host_read(a, rd);
            check($sformatf("rand_rd_%0h", a), rd, exp_read(a));
          end
        endcase
      end
    end

    // Starve the watchdog with failsafe width 300.
    host_write(A_CTRL, 16'h3);
    host_write(A_FS, 16'd300);
    for (int k = 0; k < WDOG_TICKS; k++) begin
      run_tick("wdog");
      host_read(A_STATUS, rd);
      check($sformatf("wdog_status_%0d", k), rd, exp_read(A_STATUS));
    end
    check("fs_status_bit", rd[1], 1);
    for (int i = 0; i < NCH; i++) check($sformatf("fs_width_ch%0d", i), last_dat[i], 300);

    // Stalled PWM slave: overrun, held cycle, pending tick replayed.
    stall = 1;
    wait_mcyc("stall");
    repeat (3 * TICK_DIV) @(negedge clk);
    check("stall_mcyc_held", m_cyc_o, 1);
    check("stall_madr", m_adr_o, 7'h10);
    host_read(A_STATUS, rd);
    check("stall_status", rd, 16'hF);
    stall = 0;
    run_tick("stall_a");
    run_tick("stall_b");
    host_read(A_STATUS, rd);
    check("ovr_cleared", rd, 16'h3);

    // Clear failsafe; slew resumes from 300.
    host_write(A_CTRL, 16'h3);
    host_write(A_TGT, 16'd340);
    run_tick("resume");
    check("resume_ch0", last_dat[0], 316);

    // Disarm mid-ramp.
    for (int i = 0; i < NCH; i++) host_write(A_TGT + 7'(2 * i), 16'(2000 + $urandom_range(0, 999)));
    run_tick("preramp");
    host_write(A_TGT, 16'd2500);
    host_write(A_CTRL, 16'h0);
    run_tick("disarm");
    for (int i = 0; i < NCH; i++) check($sformatf("disarm_ch%0d", i), last_dat[i], 0);

    // Reset during a stalled master write.
    host_write(A_CTRL, 16'h1);
    host_write(A_TGT + 7'h4, 16'd500);
    stall = 1;
    wait_mcyc("rstw");
    @(negedge clk);
    rst = 1;
    #1;
    check("rstw_mcyc", m_cyc_o, 0);
    check("rstw_mstb", m_stb_o, 0);
    check("rstw_mdat", m_dat_o, 0);
    @(negedge clk);
    rst = 0;
    stall = 0;
    mq.delete();
    model_reset();
    host_read(A_STATUS, rd);
    check("post_rst_status", rd, 0);
    host_read(A_TGT + 7'h4, rd);
    check("post_rst_tgt2", rd, 0);
    run_tick("post_rst");
    for (int i = 0; i < NCH; i++) check($sformatf("post_rst_ch%0d", i), last_dat[i], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
